// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DIV_WIDTH_DEFAULT = 8;

  // Bits needed to hold an iteration count from 0 up to w inclusive.
  function automatic int unsigned div_cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sub_nbit.sv
// N-bit subtractor built as a + ~b + 1; borrow is the inverted carry out.
module sub_nbit #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0] sum;

  assign sum    = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
  assign diff   = sum[N-1:0];
  assign borrow = ~sum[N];

endmodule

// File: rtl/div8_seq.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock,
// with a start/done handshake.
module div8_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = div_cnt_width(WIDTH);
  localparam int unsigned TW = WIDTH + 1;

  state_t           state;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] dvsr_reg;
  logic [CW-1:0]    count;

  logic [TW-1:0]    t_val;
  logic [TW-1:0]    d_val;
  logic             borrow;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             unused_d_msb;

  // One restoring step: trial-subtract the divisor from {R, Q[MSB]}.
  assign t_val = {r_reg, q_reg[WIDTH-1]};

  sub_nbit #(
    .N(TW)
  ) u_sub (
    .a      (t_val),
    .b      ({1'b0, dvsr_reg}),
    .diff   (d_val),
    .borrow (borrow)
  );

  // R < divisor always holds, so a borrow-free difference never sets its MSB.
  assign unused_d_msb = d_val[WIDTH];
  assign r_next       = borrow ? t_val[WIDTH-1:0] : d_val[WIDTH-1:0];
  assign q_next       = {q_reg[WIDTH-2:0], ~borrow};

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);

  // Control FSM, iteration counter and shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      q_reg       <= '0;
      r_reg       <= '0;
      dvsr_reg    <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvsr_reg <= divisor;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              q_reg       <= dividend;
              r_reg       <= '0;
              count       <= CW'(WIDTH);
              div_by_zero <= 1'b0;
              state       <= RUN;
            end
          end
        end
        RUN: begin
          q_reg <= q_next;
          r_reg <= r_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            quotient  <= q_next;
            remainder <= r_next;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div8_seq.sv
// Self-checking bench for div8_seq: directed cases, then a randomized
// back-to-back sweep against plain integer division.
module tb_div8_seq;

  localparam int unsigned W = 8;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         start    = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor  = '0;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  div8_seq #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and check it against integer division.
  task automatic do_op(input string tag, input int a, input int b, input bit poke);
    int guard;
    int lat;
    int exp_q;
    int exp_r;
    int extra;
    exp_q = (b == 0) ? ((1 << W) - 1) : a / b;
    exp_r = (b == 0) ? a : a % b;
    guard = 0;
    while (!ready && guard < 40) begin
      tick();
      guard++;
    end
    check({tag, "_ready"}, int'(ready), 1);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = W'(8'hA5);
    divisor  = W'(8'h5A);
    check({tag, "_busy"}, int'(busy), (b != 0) ? 1 : 0);
    check({tag, "_notready"}, int'(ready), 0);
    lat = 0;
    while (!done && lat < 40) begin
      if (poke && lat == 2) begin
        start    = 1'b1;
        dividend = W'(77);
        divisor  = W'(4);
      end
      if (poke && lat == 4) start = 1'b0;
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, (b == 0) ? 0 : int'(W));
    check({tag, "_q"}, int'(quotient), exp_q);
    check({tag, "_r"}, int'(remainder), exp_r);
    check({tag, "_dbz"}, int'(div_by_zero), (b == 0) ? 1 : 0);
    tick();
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_ready_after"}, int'(ready), 1);
    if (poke) begin
      extra = 0;
      repeat (12) begin
        tick();
        if (done) extra++;
      end
      check({tag, "_extra_done"}, extra, 0);
      check({tag, "_q_hold"}, int'(quotient), exp_q);
    end
  endtask

  initial begin
    int a;
    int b;
    int lat;
    int first_cyc;
    int done_seen;

    // Reset state
    #12;
    check("rst_ready", int'(ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_q", int'(quotient), 0);
    check("rst_r", int'(remainder), 0);
    check("rst_dbz", int'(div_by_zero), 0);
    #1 rst_n = 1'b1;
    tick();

    do_op("d100_7", 100, 7, 1'b0);
    do_op("d255_1", 255, 1, 1'b0);
    do_op("d5_9", 5, 9, 1'b0);
    do_op("d255_255", 255, 255, 1'b0);
    do_op("d0_3", 0, 3, 1'b0);
    do_op("d200_0", 200, 0, 1'b0);
    do_op("d9_3", 9, 3, 1'b0);
    do_op("poke100_7", 100, 7, 1'b1);

    // Asynchronous reset in the middle of an operation
    dividend = W'(100);
    divisor  = W'(7);
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_q", int'(quotient), 0);
    check("midrst_r", int'(remainder), 0);
    check("midrst_ready", int'(ready), 1);
    check("midrst_busy", int'(busy), 0);
    done_seen = 0;
    repeat (3) begin
      tick();
      if (done) done_seen++;
    end
    #1 rst_n = 1'b1;
    repeat (10) begin
      tick();
      if (done) done_seen++;
    end
    check("midrst_no_done", done_seen, 0);
    do_op("d50_6", 50, 6, 1'b0);

    // Back-to-back random sweep with start held high
    start     = 1'b1;
    first_cyc = cyc;
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(255, 0));
      b = int'($urandom_range(255, 1));
      dividend = W'(a);
      divisor  = W'(b);
      tick();
      dividend = W'($urandom);
      divisor  = W'($urandom);
      lat = 0;
      while (!done && lat < 40) begin
        tick();
        lat++;
      end
      check("sweep_latency", lat, int'(W));
      check("sweep_q", int'(quotient), a / b);
      check("sweep_r", int'(remainder), a % b);
      if (int'(quotient) != a / b || int'(remainder) != a % b) begin
        $display("sweep operands %0d / %0d gave q=%0d r=%0d", a, b, quotient, remainder);
        $fatal(1, "sweep result wrong");
      end
      tick();
    end
    check("sweep_throughput", cyc - first_cyc, 1000 * int'(W + 2));
    start = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/div8_seq.md
Name: div8_seq

Overview:
- Multi-cycle unsigned restoring divider: the subtract/inverse counterpart to the comb adder library.
- Computes quotient and remainder of an 8-bit dividend by an 8-bit divisor, one quotient bit per clock.
- Uses a start/done handshake.
- Sits in the sequential datapath library beside the comb arithmetic blocks; later ALU/CPU stages consume it.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; accepted only when ready=1
- dividend  input  WIDTH  numerator, sampled on the accepting edge
- divisor  input  WIDTH  denominator, sampled on the accepting edge
- ready  output  1  high in IDLE only (combinational from state)
- busy  output  1  high in RUN only
- done  output  1  one-cycle pulse, results valid
- quotient  output  WIDTH  result, held stable until the next accepted start
- remainder  output  WIDTH  result, held stable until the next accepted start
- div_by_zero  output  1  set with done when divisor==0; held like the results

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; quotient, remainder, div_by_zero, done and the internal count are all 0.
  - ready=1 and busy=0 while in reset.
  - Reset mid-RUN abandons the operation; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1 on edge E0:
  - Latch the divisor.
  - If divisor!=0: load the shift register Q=dividend, clear R=0, count=WIDTH, go to RUN.
  - If divisor==0: quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1, go to DONE (done high in the cycle after E0).
  - In both cases div_by_zero is cleared (or set, for divisor 0) at E0.
- RUN, each edge (iterations 1..WIDTH):
  - Form the (WIDTH+1)-bit partial value T={R, Q[MSB]}.
  - Compute D=T−divisor, zero-extended to WIDTH+1 bits.
  - No borrow: R=D[WIDTH-1:0] and shift a 1 into Q.
  - Borrow: R=T[WIDTH-1:0] and shift a 0 into Q.
  - count decrements; on the edge where count reaches 0, go to DONE.
- DONE: done=1 for exactly one cycle; quotient=Q and remainder=R are visible. The next edge returns to IDLE.
- Latency: a nonzero divisor accepted at E0 gives done=1 during the cycle after edge E0+WIDTH.
  - Throughput: one result per WIDTH+2 cycles with start held high.
- start while RUN or DONE is ignored and does not affect the operation in flight. Operand changes after E0 are ignored.
- quotient and remainder outputs update only when entering DONE. During RUN they keep the previous result.
- Arithmetic invariant: dividend == quotient*divisor + remainder, with remainder < divisor, for every divisor!=0.
- No X propagation: all registers have reset values.

Decomposition:
- Package div_pkg holds:
  - the state enum (IDLE, RUN, DONE), 2 bits;
  - localparam DIV_WIDTH_DEFAULT=8;
  - a counter width function, clog2(WIDTH+1).
- Sub-module sub_nbit, parameter N (instantiated with N=WIDTH+1):
  - inputs a, b; outputs diff and borrow;
  - implemented as a + ~b + 1 (carry_in=1), with borrow = ~carry_out;
  - this mirrors the adder's carry convention.
- All control logic (FSM, counter, shift register) lives in div8_seq.

Test Plan:
- 100/7: start with dividend=100, divisor=7 → done exactly 8 cycles after the accept edge; quotient=14, remainder=2, div_by_zero=0; ready returns 1 the cycle after done.
- Edge values:
  - 255/1 → quotient=255, remainder=0.
  - 5/9 → quotient=0, remainder=5.
  - 255/255 → quotient=1, remainder=0.
  - 0/3 → quotient=0, remainder=0.
- Divide-by-zero: 200/0 → done 1 cycle after accept; quotient=255, remainder=200, div_by_zero=1. A following 9/3 clears div_by_zero and gives quotient=3, remainder=0.
- start pulsed mid-RUN with different operands (e.g. 77/4 during 100/7) → ignored; the result is still 14 r 2 with exactly one done pulse.
- Reset mid-op: rst_n=0 asynchronously at iteration 4 → outputs 0 immediately, no done. After release, 50/6 → quotient=8, remainder=2.
- Random sweep of ≥1000 operand pairs, divisor!=0, start held high back-to-back → compare against dividend/divisor and dividend%divisor; on mismatch, $display the operands and results and call $fatal.
